// File: rtl/ex_stage_pkg.sv
// Shared ISA/CPU constants and types for the EX stage and its multiply/divide unit.
package ex_stage_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int WORD_ADDR_W = 30;
   localparam int REG_ADDR_W  = 5;
   localparam int ALU_OP_W    = 4;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;
   localparam int ISA_EXP_W   = 3;
   localparam int MD_ITER     = 32;

   localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'h0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'h1;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'h2;
   localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'h3;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADDS = 4'h4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'h5;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUBS = 4'h6;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'h7;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SHRL = 4'h8;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'h9;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MUL  = 4'hA;
   localparam logic [ALU_OP_W-1:0] ALU_OP_DIVU = 4'hB;
   localparam logic [ALU_OP_W-1:0] ALU_OP_REMU = 4'hC;

   localparam logic [MEM_OP_W-1:0]  MEM_OP_NOP       = 2'h0;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP      = 2'h0;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP   = 3'h0;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW = 3'h3;

   typedef enum logic [1:0] {
      MD_STATE_IDLE = 2'h0,
      MD_STATE_RUN  = 2'h1,
      MD_STATE_DONE = 2'h2
   } md_state_t;

   typedef struct packed {
      logic [WORD_ADDR_W-1:0] pc;
      logic                   en;
      logic                   br_flag;
      logic [MEM_OP_W-1:0]    mem_op;
      logic [WORD_DATA_W-1:0] mem_wr_data;
      logic [CTRL_OP_W-1:0]   ctrl_op;
      logic [REG_ADDR_W-1:0]  dst_addr;
      logic                   gpr_we_;
      logic [ISA_EXP_W-1:0]   exp_code;
      logic [WORD_DATA_W-1:0] out;
   } ex_bundle_t;

   localparam ex_bundle_t EX_BUNDLE_RST = '{
      pc:          '0,
      en:          1'b0,
      br_flag:     1'b0,
      mem_op:      MEM_OP_NOP,
      mem_wr_data: '0,
      ctrl_op:     CTRL_OP_NOP,
      dst_addr:    '0,
      gpr_we_:     1'b1,
      exp_code:    ISA_EXP_NO_EXP,
      out:         '0
   };

   function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply / divide unit: one result bit per cycle,
// shift-add multiply (low word) and restoring division (quotient or remainder).
module ex_muldiv
   import ex_stage_pkg::*;
#(
   parameter int ITER = MD_ITER
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ALU_OP_W-1:0]    op,
   input  logic [WORD_DATA_W-1:0] in_0,
   input  logic [WORD_DATA_W-1:0] in_1,
   input  logic                   abort,
   input  logic                   hold,
   output logic                   busy,
   output logic                   done,
   output logic [WORD_DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(ITER);

   md_state_t               state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [ALU_OP_W-1:0]     op_reg, op_next;
   // acc: product accumulator / partial remainder
   // sft: multiplier (shifted right) / dividend-becoming-quotient (shifted left)
   // opd: multiplicand (shifted left) / divisor
   logic [WORD_DATA_W-1:0]  acc_reg, acc_next;
   logic [WORD_DATA_W-1:0]  sft_reg, sft_next;
   logic [WORD_DATA_W-1:0]  opd_reg, opd_next;
   logic [WORD_DATA_W:0]    trial;

   // The partial remainder is always below the divisor, so bit 32 is a clean borrow flag.
   assign trial = {acc_reg, sft_reg[WORD_DATA_W-1]} - {1'b0, opd_reg};

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      op_next    = op_reg;
      acc_next   = acc_reg;
      sft_next   = sft_reg;
      opd_next   = opd_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         MD_STATE_IDLE: begin
            if (start) begin
               busy       = 1'b1;
               state_next = MD_STATE_RUN;
               cnt_next   = '0;
               op_next    = op;
               acc_next   = '0;
               if (op == ALU_OP_MUL) begin
                  sft_next = in_1;
                  opd_next = in_0;
               end else begin
                  sft_next = in_0;
                  opd_next = in_1;
               end
            end
         end
         MD_STATE_RUN: begin
            busy     = 1'b1;
            cnt_next = cnt_reg + CNT_W'(1);
            if (op_reg == ALU_OP_MUL) begin
               if (sft_reg[0]) begin
                  acc_next = acc_reg + opd_reg;
               end
               opd_next = opd_reg << 1;
               sft_next = sft_reg >> 1;
            end else if (!trial[WORD_DATA_W]) begin
               acc_next = trial[WORD_DATA_W-1:0];
               sft_next = {sft_reg[WORD_DATA_W-2:0], 1'b1};
            end else begin
               acc_next = {acc_reg[WORD_DATA_W-2:0], sft_reg[WORD_DATA_W-1]};
               sft_next = {sft_reg[WORD_DATA_W-2:0], 1'b0};
            end
            if (abort) begin
               state_next = MD_STATE_IDLE;
            end else if (cnt_reg == CNT_W'(ITER - 1)) begin
               state_next = MD_STATE_DONE;
            end
         end
         MD_STATE_DONE: begin
            done = 1'b1;
            if (abort || !hold) begin
               state_next = MD_STATE_IDLE;
            end
         end
         default: state_next = MD_STATE_IDLE;
      endcase
   end

   assign result = (op_reg == ALU_OP_DIVU) ? sft_reg : acc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= MD_STATE_IDLE;
         cnt_reg   <= '0;
         op_reg    <= ALU_OP_NOP;
         acc_reg   <= '0;
         sft_reg   <= '0;
         opd_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         op_reg    <= op_next;
         acc_reg   <= acc_next;
         sft_reg   <= sft_next;
         opd_reg   <= opd_next;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: single-cycle ALU with overflow detection, iterative
// multiply/divide with stall request, and the EX/MEM pipeline register.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int MD_ITER = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [WORD_ADDR_W-1:0] id_pc,
   input  logic                   id_en,
   input  logic [ALU_OP_W-1:0]    id_alu_op,
   input  logic [WORD_DATA_W-1:0] id_alu_in_0,
   input  logic [WORD_DATA_W-1:0] id_alu_in_1,
   input  logic                   id_br_flag,
   input  logic [MEM_OP_W-1:0]    id_mem_op,
   input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
   input  logic [CTRL_OP_W-1:0]   id_ctrl_op,
   input  logic [REG_ADDR_W-1:0]  id_dst_addr,
   input  logic                   id_gpr_we_,
   input  logic [ISA_EXP_W-1:0]   id_exp_code,
   output logic                   md_busy,
   output logic [WORD_DATA_W-1:0] fwd_data,
   output logic [WORD_ADDR_W-1:0] ex_pc,
   output logic                   ex_en,
   output logic                   ex_br_flag,
   output logic [MEM_OP_W-1:0]    ex_mem_op,
   output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
   output logic [CTRL_OP_W-1:0]   ex_ctrl_op,
   output logic [REG_ADDR_W-1:0]  ex_dst_addr,
   output logic                   ex_gpr_we_,
   output logic [ISA_EXP_W-1:0]   ex_exp_code,
   output logic [WORD_DATA_W-1:0] ex_out
);

   logic [WORD_DATA_W-1:0] alu_result;
   logic [WORD_DATA_W-1:0] sum;
   logic [WORD_DATA_W-1:0] diff;
   logic                   alu_ovf;
   logic                   ovf_taken;
   logic                   is_md;
   logic                   md_start;
   logic                   md_abort;
   logic                   md_busy_raw;
   logic                   md_done;
   logic [WORD_DATA_W-1:0] md_result;
   ex_bundle_t             ex_reg, ex_next;

   assign sum  = id_alu_in_0 + id_alu_in_1;
   assign diff = id_alu_in_0 - id_alu_in_1;

   always_comb begin
      alu_result = '0;
      alu_ovf    = 1'b0;
      case (id_alu_op)
         ALU_OP_AND:  alu_result = id_alu_in_0 & id_alu_in_1;
         ALU_OP_OR:   alu_result = id_alu_in_0 | id_alu_in_1;
         ALU_OP_XOR:  alu_result = id_alu_in_0 ^ id_alu_in_1;
         ALU_OP_ADDU: alu_result = sum;
         ALU_OP_SUBU: alu_result = diff;
         ALU_OP_SHRL: alu_result = id_alu_in_0 >> id_alu_in_1[4:0];
         ALU_OP_SHLL: alu_result = id_alu_in_0 << id_alu_in_1[4:0];
         ALU_OP_ADDS: begin
            alu_result = sum;
            alu_ovf    = (id_alu_in_0[31] == id_alu_in_1[31]) && (sum[31] != id_alu_in_0[31]);
         end
         ALU_OP_SUBS: begin
            alu_result = diff;
            alu_ovf    = (id_alu_in_0[31] != id_alu_in_1[31]) && (diff[31] != id_alu_in_0[31]);
         end
         default: alu_result = '0;
      endcase
   end

   assign is_md    = is_md_op(id_alu_op);
   assign md_start = id_en && is_md && !flush;
   // A flush arriving during a stall is dropped, so the unit must not abort either.
   assign md_abort = flush && !stall;

   ex_muldiv #(
      .ITER   (MD_ITER)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .op     (id_alu_op),
      .in_0   (id_alu_in_0),
      .in_1   (id_alu_in_1),
      .abort  (md_abort),
      .hold   (stall),
      .busy   (md_busy_raw),
      .done   (md_done),
      .result (md_result)
   );

   assign md_busy  = id_en && md_busy_raw;
   assign fwd_data = is_md ? (md_done ? md_result : '0) : alu_result;

   // Overflow only replaces a clean exception code of a valid instruction.
   assign ovf_taken = alu_ovf && id_en && (id_exp_code == ISA_EXP_NO_EXP);

   always_comb begin
      ex_next             = EX_BUNDLE_RST;
      ex_next.pc          = id_pc;
      ex_next.en          = id_en;
      ex_next.br_flag     = id_br_flag;
      ex_next.mem_op      = ovf_taken ? MEM_OP_NOP : id_mem_op;
      ex_next.mem_wr_data = id_mem_wr_data;
      ex_next.ctrl_op     = id_ctrl_op;
      ex_next.dst_addr    = id_dst_addr;
      ex_next.gpr_we_     = ovf_taken ? 1'b1 : id_gpr_we_;
      ex_next.exp_code    = ovf_taken ? ISA_EXP_OVERFLOW : id_exp_code;
      ex_next.out         = fwd_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_reg <= EX_BUNDLE_RST;
      end else if (!stall) begin
         if (flush || md_busy) begin
            ex_reg <= EX_BUNDLE_RST;
         end else begin
            ex_reg <= ex_next;
         end
      end
   end

   assign ex_pc          = ex_reg.pc;
   assign ex_en          = ex_reg.en;
   assign ex_br_flag     = ex_reg.br_flag;
   assign ex_mem_op      = ex_reg.mem_op;
   assign ex_mem_wr_data = ex_reg.mem_wr_data;
   assign ex_ctrl_op     = ex_reg.ctrl_op;
   assign ex_dst_addr    = ex_reg.dst_addr;
   assign ex_gpr_we_     = ex_reg.gpr_we_;
   assign ex_exp_code    = ex_reg.exp_code;
   assign ex_out         = ex_reg.out;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random ops against an arithmetic reference.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [29:0] id_pc;
   logic        id_en;
   logic [3:0]  id_alu_op;
   logic [31:0] id_alu_in_0, id_alu_in_1;
   logic        id_br_flag;
   logic [1:0]  id_mem_op;
   logic [31:0] id_mem_wr_data;
   logic [1:0]  id_ctrl_op;
   logic [4:0]  id_dst_addr;
   logic        id_gpr_we_;
   logic [2:0]  id_exp_code;
   logic        md_busy;
   logic [31:0] fwd_data;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag, ex_gpr_we_;
   logic [1:0]  ex_mem_op, ex_ctrl_op;
   logic [31:0] ex_mem_wr_data, ex_out;
   logic [4:0]  ex_dst_addr;
   logic [2:0]  ex_exp_code;

   int checks   = 0;
   int failures = 0;

   // expected EX/MEM bundle for the instruction most recently driven
   logic [29:0] e_pc;
   logic        e_en, e_br, e_we;
   logic [1:0]  e_mem, e_ctrl;
   logic [31:0] e_wd, e_out;
   logic [4:0]  e_dst;
   logic [2:0]  e_exp;

   localparam longint S32_MAX = 64'sh0000_0000_7FFF_FFFF;
   localparam longint S32_MIN = -64'sh0000_0000_8000_0000;

   ex_stage #(.MD_ITER(32)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
      .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
      .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
      .id_exp_code(id_exp_code), .md_busy(md_busy), .fwd_data(fwd_data),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      int unsigned     sh = b % 32;
      case (op)
         4'h1: return a & b;
         4'h2: return a | b;
         4'h3: return a ^ b;
         4'h4, 4'h5: return 32'(ua + ub);
         4'h6, 4'h7: return 32'(ua - ub);
         4'h8: return a >> sh;
         4'h9: return a << sh;
         4'hA: return 32'(ua * ub);
         4'hB: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'hC: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      if (op == 4'h4) r = sa + sb;
      else if (op == 4'h6) r = sa - sb;
      else return 1'b0;
      return (r > S32_MAX) || (r < S32_MIN);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic [2:0] xin);
      logic ovf_taken;
      id_alu_op      = op;
      id_alu_in_0    = a;
      id_alu_in_1    = b;
      id_en          = en;
      id_exp_code    = xin;
      id_pc          = 30'($urandom);
      id_br_flag     = 1'($urandom);
      id_mem_op      = 2'($urandom);
      id_mem_wr_data = $urandom;
      id_ctrl_op     = 2'($urandom);
      id_dst_addr    = 5'($urandom);
      id_gpr_we_     = 1'($urandom);
      ovf_taken = en && (xin == 3'd0) && ref_ovf(op, a, b);
      e_pc   = id_pc;
      e_en   = en;
      e_br   = id_br_flag;
      e_wd   = id_mem_wr_data;
      e_ctrl = id_ctrl_op;
      e_dst  = id_dst_addr;
      e_out  = ref_result(op, a, b);
      e_exp  = (xin != 3'd0) ? xin : (ovf_taken ? 3'd3 : 3'd0);
      e_we   = ovf_taken ? 1'b1 : id_gpr_we_;
      e_mem  = ovf_taken ? 2'd0 : id_mem_op;
   endtask

   task automatic chk_ex(input string tag);
      chk({tag, ".ex_out"}, ex_out, e_out);
      chk({tag, ".ex_en"}, 32'(ex_en), 32'(e_en));
      chk({tag, ".ex_pc"}, 32'(ex_pc), 32'(e_pc));
      chk({tag, ".ex_br_flag"}, 32'(ex_br_flag), 32'(e_br));
      chk({tag, ".ex_mem_op"}, 32'(ex_mem_op), 32'(e_mem));
      chk({tag, ".ex_mem_wr_data"}, ex_mem_wr_data, e_wd);
      chk({tag, ".ex_ctrl_op"}, 32'(ex_ctrl_op), 32'(e_ctrl));
      chk({tag, ".ex_dst_addr"}, 32'(ex_dst_addr), 32'(e_dst));
      chk({tag, ".ex_gpr_we_"}, 32'(ex_gpr_we_), 32'(e_we));
      chk({tag, ".ex_exp_code"}, 32'(ex_exp_code), 32'(e_exp));
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".ex_pc"}, 32'(ex_pc), 32'h0);
      chk({tag, ".ex_en"}, 32'(ex_en), 32'h0);
      chk({tag, ".ex_br_flag"}, 32'(ex_br_flag), 32'h0);
      chk({tag, ".ex_mem_op"}, 32'(ex_mem_op), 32'h0);
      chk({tag, ".ex_mem_wr_data"}, ex_mem_wr_data, 32'h0);
      chk({tag, ".ex_ctrl_op"}, 32'(ex_ctrl_op), 32'h0);
      chk({tag, ".ex_dst_addr"}, 32'(ex_dst_addr), 32'h0);
      chk({tag, ".ex_gpr_we_"}, 32'(ex_gpr_we_), 32'h1);
      chk({tag, ".ex_exp_code"}, 32'(ex_exp_code), 32'h0);
      chk({tag, ".ex_out"}, ex_out, 32'h0);
   endtask

   task automatic single_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic en, input logic [2:0] xin);
      @(negedge clk);
      drive(op, a, b, en, xin);
      #1;
      chk({tag, ".fwd_data"}, fwd_data, e_out);
      chk({tag, ".md_busy"}, 32'(md_busy), 32'h0);
      @(posedge clk);
      #1;
      chk_ex(tag);
      $display("op=%h a=%h b=%h en=%0d xin=%0d -> ex_out=%h exp=%0d", op, a, b, en, xin, ex_out, ex_exp_code);
   endtask

   task automatic md_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall_cycles);
      int busy_cnt = 0;
      @(negedge clk);
      drive(op, a, b, 1'b1, 3'd0);
      #1;
      while (md_busy === 1'b1 && busy_cnt < 100) begin
         busy_cnt++;
         if (busy_cnt == 2) chk({tag, ".fwd_while_busy"}, fwd_data, 32'h0);
         @(posedge clk);
         #1;
         chk({tag, ".bubble_en"}, 32'(ex_en), 32'h0);
         @(negedge clk);
         #1;
      end
      chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({tag, ".fwd_done"}, fwd_data, e_out);
      if (stall_cycles > 0) begin
         stall = 1'b1;
         repeat (stall_cycles) begin
            @(posedge clk);
            #1;
            chk({tag, ".held_en"}, 32'(ex_en), 32'h0);
            chk({tag, ".held_out"}, ex_out, 32'h0);
            @(negedge clk);
            #1;
            chk({tag, ".fwd_in_done"}, fwd_data, e_out);
            chk({tag, ".busy_in_done"}, 32'(md_busy), 32'h0);
         end
         stall = 1'b0;
      end
      @(posedge clk);
      #1;
      chk_ex(tag);
      $display("md op=%h a=%h b=%h stall=%0d busy=%0d -> ex_out=%h", op, a, b, stall_cycles, busy_cnt, ex_out);
   endtask

   initial begin
      logic [29:0] p_pc;
      logic [31:0] p_out;
      logic [3:0]  rop;

      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(ALU_OP_ADDU, 32'd1, 32'd2, 1'b1, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_rst("reset");
      @(negedge clk);
      reset = 1'b0;
      id_en = 1'b0;

      single_op("addu_5_7", ALU_OP_ADDU, 32'd5, 32'd7, 1'b1, 3'd0);
      single_op("adds_ovf", ALU_OP_ADDS, 32'h7FFF_FFFF, 32'd1, 1'b1, 3'd0);
      single_op("subs_ovf", ALU_OP_SUBS, 32'h8000_0000, 32'd1, 1'b1, 3'd0);
      single_op("adds_ovf_prio", ALU_OP_ADDS, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 3'd2);
      single_op("adds_ovf_noen", ALU_OP_ADDS, 32'h8000_0000, 32'h8000_0000, 1'b0, 3'd0);
      single_op("shll_mask", ALU_OP_SHLL, 32'd1, 32'd33, 1'b1, 3'd0);
      single_op("shrl_mask", ALU_OP_SHRL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3'd0);
      single_op("nop", ALU_OP_NOP, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 3'd0);

      // stall wins over flush; flush alone loads a bubble
      p_pc  = e_pc;
      p_out = e_out;
      @(negedge clk);
      drive(ALU_OP_ADDU, 32'd3, 32'd4, 1'b1, 3'd0);
      stall = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_over_flush.ex_out", ex_out, p_out);
      chk("stall_over_flush.ex_pc", 32'(ex_pc), 32'(p_pc));
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      chk_rst("flush_bubble");
      @(negedge clk);
      flush = 1'b0;

      md_op("mul_basic", ALU_OP_MUL, 32'h0001_0001, 32'h0001_0001, 0);
      md_op("divu_100_7", ALU_OP_DIVU, 32'd100, 32'd7, 0);
      md_op("remu_100_7", ALU_OP_REMU, 32'd100, 32'd7, 0);
      md_op("divu_by0", ALU_OP_DIVU, 32'd9, 32'd0, 0);
      md_op("remu_by0", ALU_OP_REMU, 32'd9, 32'd0, 0);
      md_op("mul_stall3", ALU_OP_MUL, 32'hFFFF_FFFF, 32'h0000_0003, 3);

      // flush in cycle 10 of a divide
      @(negedge clk);
      drive(ALU_OP_DIVU, 32'd1000, 32'd3, 1'b1, 3'd0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_div.busy_before", 32'(md_busy), 32'h1);
      @(posedge clk);
      #1;
      chk("flush_div.ex_en", 32'(ex_en), 32'h0);
      @(negedge clk);
      flush = 1'b0;
      drive(ALU_OP_ADDU, 32'd1, 32'd1, 1'b1, 3'd0);
      #1;
      chk("flush_div.busy_after", 32'(md_busy), 32'h0);
      chk("flush_div.fwd", fwd_data, 32'd2);
      @(posedge clk);
      #1;
      chk_ex("flush_div.addu");
      $display("flush during divide -> following addu ex_out=%h", ex_out);

      // reset in the middle of a multiply
      @(negedge clk);
      drive(ALU_OP_MUL, 32'd12345, 32'd678, 1'b1, 3'd0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      id_en = 1'b0;
      @(posedge clk);
      #1;
      chk_rst("reset_mid_run");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_mid_run.md_busy", 32'(md_busy), 32'h0);
      $display("reset during multiply -> ex_en=%0d md_busy=%0d", ex_en, md_busy);
      md_op("mul_after_reset", ALU_OP_MUL, 32'd12345, 32'd678, 0);

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 9));
         single_op("rand_alu", rop, pick(), pick(), 1'($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      end
      for (int i = 0; i < 9; i++) begin
         rop = 4'($urandom_range(10, 12));
         md_op("rand_md", rop, pick(), ($urandom_range(0, 3) == 0) ? 32'd0 : pick(),
               $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
